// File: rtl/instr_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order requests to a variable-latency instruction
// memory and buffers up to DEPTH PC-tagged instructions for the datapath.
`timescale 1ns/1ps
module instr_prefetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imemReqValid,
    output logic [31:0] imemReqAddr,
    input  logic        imemReqReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    input  logic        redirectValid,
    input  logic [31:0] redirectPC,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] pcQ,
    output logic [31:0] pcPlus4
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [PW-1:0] head_ptr_r;
    logic [PW-1:0] alloc_ptr_r;
    logic [PW-1:0] fill_ptr_r;
    logic [CW-1:0] alloc_cnt_r;
    logic [CW-1:0] filled_cnt_r;
    logic [CW-1:0] drop_cnt_r;
    logic [31:0]   pc_buf_r   [DEPTH];
    logic [31:0]   data_buf_r [DEPTH];

    logic [CW:0]   credit_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          fill_s;
    logic          head_filled_s;
    logic          pop_fire_s;
    logic [CW-1:0] unfilled_s;
    logic [CW-1:0] alloc_next_s;
    logic [CW-1:0] filled_next_s;
    logic [CW-1:0] drop_next_s;

    // Handshake decode and next-state counter arithmetic.
    always_comb begin
        credit_s      = {1'b0, alloc_cnt_r} + {1'b0, drop_cnt_r};
        req_valid_s   = !reset && (credit_s < DEPTH_W);
        req_fire_s    = req_valid_s && imemReqReady;
        fill_s        = imemRespValid && (drop_cnt_r == CW'(0));
        // Fills land in order from the head, so the head is filled whenever any entry is.
        head_filled_s = !reset && (filled_cnt_r != CW'(0));
        pop_fire_s    = head_filled_s && instrReady;
        unfilled_s    = alloc_cnt_r - filled_cnt_r;
        alloc_next_s  = alloc_cnt_r + CW'(req_fire_s) - CW'(pop_fire_s);
        filled_next_s = filled_cnt_r + CW'(fill_s) - CW'(pop_fire_s);
        if (redirectValid) begin
            // Everything allocated but unfilled, plus a request issued now, is owed a discard.
            drop_next_s = drop_cnt_r + unfilled_s + CW'(req_fire_s) - CW'(imemRespValid);
        end else if (imemRespValid && !fill_s) begin
            drop_next_s = drop_cnt_r - CW'(1);
        end else begin
            drop_next_s = drop_cnt_r;
        end
    end

    // Fetch PC, pointers and occupancy counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r   <= RESET_PC;
            head_ptr_r   <= PW'(0);
            alloc_ptr_r  <= PW'(0);
            fill_ptr_r   <= PW'(0);
            alloc_cnt_r  <= CW'(0);
            filled_cnt_r <= CW'(0);
            drop_cnt_r   <= CW'(0);
        end else if (redirectValid) begin
            fetch_pc_r   <= redirectPC & ~32'h0000_0003;
            head_ptr_r   <= PW'(0);
            alloc_ptr_r  <= PW'(0);
            fill_ptr_r   <= PW'(0);
            alloc_cnt_r  <= CW'(0);
            filled_cnt_r <= CW'(0);
            drop_cnt_r   <= drop_next_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_r  <= fetch_pc_r + 32'd4;
                alloc_ptr_r <= alloc_ptr_r + PW'(1);
            end
            if (fill_s) begin
                fill_ptr_r <= fill_ptr_r + PW'(1);
            end
            if (pop_fire_s) begin
                head_ptr_r <= head_ptr_r + PW'(1);
            end
            alloc_cnt_r  <= alloc_next_s;
            filled_cnt_r <= filled_next_s;
            drop_cnt_r   <= drop_next_s;
        end
    end

    // Entry payload storage; validity is tracked solely by the counters above.
    always_ff @(posedge clock) begin
        if (req_fire_s && !redirectValid) begin
            pc_buf_r[alloc_ptr_r] <= fetch_pc_r;
        end
        if (fill_s && !reset && !redirectValid) begin
            data_buf_r[fill_ptr_r] <= imemRespData;
        end
    end

    // Output drive: head entry when valid, all zeros otherwise.
    always_comb begin
        imemReqValid = req_valid_s;
        imemReqAddr  = reset ? 32'h0000_0000 : fetch_pc_r;
        if (head_filled_s) begin
            instrValid = 1'b1;
            instr      = data_buf_r[head_ptr_r];
            pcQ        = pc_buf_r[head_ptr_r];
            pcPlus4    = pc_buf_r[head_ptr_r] + 32'd4;
        end else begin
            instrValid = 1'b0;
            instr      = 32'h0000_0000;
            pcQ        = 32'h0000_0000;
            pcPlus4    = 32'h0000_0000;
        end
    end

    instr_prefetch_unit_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
        .clock         (clock),
        .reset         (reset),
        .imemRespValid (imemRespValid),
        .alloc_cnt     (alloc_cnt_r),
        .filled_cnt    (filled_cnt_r),
        .drop_cnt      (drop_cnt_r)
    );
endmodule

// Protocol and occupancy invariants of the prefetch buffer.
module instr_prefetch_unit_chk #(
    parameter int CW    = 3,
    parameter int DEPTH = 4
) (
    input logic          clock,
    input logic          reset,
    input logic          imemRespValid,
    input logic [CW-1:0] alloc_cnt,
    input logic [CW-1:0] filled_cnt,
    input logic [CW-1:0] drop_cnt
);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    a_no_orphan_resp: assert property (@(posedge clock) disable iff (reset)
        !(imemRespValid && (alloc_cnt == filled_cnt) && (drop_cnt == CW'(0))));
    a_filled_le_alloc: assert property (@(posedge clock) disable iff (reset)
        filled_cnt <= alloc_cnt);
    a_credit_bound: assert property (@(posedge clock) disable iff (reset)
        ({1'b0, alloc_cnt} + {1'b0, drop_cnt}) <= DEPTH_W);
endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit with an in-order, fixed-latency memory model and a
// pop scoreboard checking every consumed instruction against its PC.
`timescale 1ns/1ps
module tb_instr_prefetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady = 1'b0;
    logic        imemRespValid = 1'b0;
    logic [31:0] imemRespData = 32'h0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPC = 32'h0;
    logic        instrValid;
    logic        instrReady = 1'b0;
    logic [31:0] instr;
    logic [31:0] pcQ;
    logic [31:0] pcPlus4;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] pop_q[$];
    logic [31:0] req_q[$];

    instr_prefetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .imemReqValid  (imemReqValid),
        .imemReqAddr   (imemReqAddr),
        .imemReqReady  (imemReqReady),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .redirectValid (redirectValid),
        .redirectPC    (redirectPC),
        .instrValid    (instrValid),
        .instrReady    (instrReady),
        .instr         (instr),
        .pcQ           (pcQ),
        .pcPlus4       (pcPlus4)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memfun(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cycle counter used for memory latency bookkeeping.
    always @(posedge clock) cyc <= cyc + 1;

    // Memory: the oldest request answers once its latency has elapsed.
    always @(negedge clock) begin
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imemRespValid = 1'b1;
            imemRespData  = memfun(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imemRespValid = 1'b0;
            imemRespData  = 32'h0;
        end
    end

    // Mid-cycle monitor: records request and pop handshakes, scores each popped instruction.
    always @(negedge clock) begin
        #2;
        if (reset) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (imemReqValid && imemReqReady) begin
                req_q.push_back(imemReqAddr);
                mq_addr.push_back(imemReqAddr);
                mq_due.push_back(cyc + lat);
            end
            if (instrValid && instrReady) begin
                pop_q.push_back(pcQ);
                chk_eq("pop_instr", instr, memfun(pcQ));
                chk_eq("pop_pc_plus4", pcPlus4, pcQ + 32'd4);
            end
        end
    end

    task automatic do_reset(input int l, input logic rr, input logic ir);
        @(negedge clock);
        reset = 1'b1;
        redirectValid = 1'b0;
        redirectPC = 32'h0;
        lat = l;
        imemReqReady = rr;
        instrReady = ir;
        repeat (2) @(negedge clock);
        pop_q.delete();
        req_q.delete();
        reset = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_pops(input int n, input string tag);
        for (int i = 0; i < 60 && pop_q.size() < n; i++) begin
            @(negedge clock);
            #3;
        end
        chk_eq(tag, pop_q.size(), n);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk_eq({tag, "_req_valid"}, imemReqValid, 1'b0);
        chk_eq({tag, "_req_addr"}, imemReqAddr, 32'h0);
        chk_eq({tag, "_instr_valid"}, instrValid, 1'b0);
        chk_eq({tag, "_instr"}, instr, 32'h0);
        chk_eq({tag, "_pcq"}, pcQ, 32'h0);
        chk_eq({tag, "_pc_plus4"}, pcPlus4, 32'h0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk_outputs_zero("rst");

        // 1: streaming at latency 1
        do_reset(1, 1'b1, 1'b1);
        chk_eq("t1_req_valid", imemReqValid, 1'b1);
        chk_eq("t1_addr0", imemReqAddr, 32'h0);
        chk_eq("t1_iv_c0", instrValid, 1'b0);
        tick();
        chk_eq("t1_addr1", imemReqAddr, 32'h4);
        chk_eq("t1_iv_c1", instrValid, 1'b0);
        tick();
        chk_eq("t1_addr2", imemReqAddr, 32'h8);
        chk_eq("t1_iv_c2", instrValid, 1'b1);
        chk_eq("t1_pcq0", pcQ, 32'h0);
        chk_eq("t1_pc4_0", pcPlus4, 32'h4);
        chk_eq("t1_instr0", instr, memfun(32'h0));
        tick();
        chk_eq("t1_pcq1", pcQ, 32'h4);
        tick();
        chk_eq("t1_pcq2", pcQ, 32'h8);

        // 2: consumer stalled, buffer fills to DEPTH then drains in order
        do_reset(1, 1'b1, 1'b0);
        repeat (8) tick();
        chk_eq("t2_req_count", req_q.size(), 4);
        chk_eq("t2_req_last", req_q[3], 32'hC);
        chk_eq("t2_req_valid_full", imemReqValid, 1'b0);
        chk_eq("t2_iv_held", instrValid, 1'b1);
        chk_eq("t2_pcq_held", pcQ, 32'h0);
        @(negedge clock);
        instrReady = 1'b1;
        #1;
        tick();
        chk_eq("t2_req_resume", imemReqValid, 1'b1);
        chk_eq("t2_addr_resume", imemReqAddr, 32'h10);
        wait_pops(5, "t2_pop_count");
        chk_eq("t2_pop0", pop_q[0], 32'h0);
        chk_eq("t2_pop1", pop_q[1], 32'h4);
        chk_eq("t2_pop2", pop_q[2], 32'h8);
        chk_eq("t2_pop3", pop_q[3], 32'hC);
        chk_eq("t2_pop4", pop_q[4], 32'h10);

        // 3: latency 3, redirect (unaligned target) with responses still in flight
        do_reset(3, 1'b1, 1'b1);
        repeat (3) tick();
        @(negedge clock);
        imemReqReady = 1'b0;
        #1;
        @(negedge clock);
        redirectValid = 1'b1;
        redirectPC = 32'h0000_0102;
        #1;
        chk_eq("t3_iv_redir", instrValid, 1'b1);
        chk_eq("t3_pcq_redir", pcQ, 32'h4);
        @(negedge clock);
        redirectValid = 1'b0;
        imemReqReady = 1'b1;
        #1;
        chk_eq("t3_iv_after", instrValid, 1'b0);
        chk_eq("t3_req_valid", imemReqValid, 1'b1);
        chk_eq("t3_addr_target", imemReqAddr, 32'h100);
        wait_pops(4, "t3_pop_count");
        chk_eq("t3_pop0", pop_q[0], 32'h0);
        chk_eq("t3_pop1", pop_q[1], 32'h4);
        chk_eq("t3_pop2", pop_q[2], 32'h100);
        chk_eq("t3_pop3", pop_q[3], 32'h104);

        // 4: redirect coinciding with request, response and pop
        do_reset(1, 1'b1, 1'b1);
        repeat (2) tick();
        @(negedge clock);
        redirectValid = 1'b1;
        redirectPC = 32'h0000_0200;
        #1;
        chk_eq("t4_req_fire", imemReqValid, 1'b1);
        chk_eq("t4_pcq_redir", pcQ, 32'h4);
        @(negedge clock);
        redirectValid = 1'b0;
        #1;
        chk_eq("t4_iv_c4", instrValid, 1'b0);
        chk_eq("t4_addr_target", imemReqAddr, 32'h200);
        tick();
        chk_eq("t4_iv_c5", instrValid, 1'b0);
        tick();
        chk_eq("t4_iv_c6", instrValid, 1'b1);
        chk_eq("t4_pcq_target", pcQ, 32'h200);
        wait_pops(4, "t4_pop_count");
        chk_eq("t4_pop1", pop_q[1], 32'h4);
        chk_eq("t4_pop2", pop_q[2], 32'h200);
        chk_eq("t4_pop3", pop_q[3], 32'h204);
        chk_eq("t4_req3", req_q[3], 32'hC);
        chk_eq("t4_req4", req_q[4], 32'h200);

        // 5: memory backpressure holds the request stable
        do_reset(1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            imemReqReady = 1'b0;
            #1;
            chk_eq("t5_hold_valid", imemReqValid, 1'b1);
            chk_eq("t5_hold_addr", imemReqAddr, 32'h8);
        end
        @(negedge clock);
        imemReqReady = 1'b1;
        #1;
        chk_eq("t5_addr_release", imemReqAddr, 32'h8);
        tick();
        chk_eq("t5_addr_next", imemReqAddr, 32'hC);
        wait_pops(4, "t5_pop_count");
        chk_eq("t5_pop2", pop_q[2], 32'h8);
        chk_eq("t5_pop3", pop_q[3], 32'hC);

        // 6: PC wrap at the top of the address space, then reset mid-stream
        do_reset(1, 1'b1, 1'b1);
        repeat (2) tick();
        @(negedge clock);
        redirectValid = 1'b1;
        redirectPC = 32'hFFFF_FFFC;
        #1;
        @(negedge clock);
        redirectValid = 1'b0;
        #1;
        chk_eq("t6_addr_top", imemReqAddr, 32'hFFFF_FFFC);
        tick();
        chk_eq("t6_addr_wrap", imemReqAddr, 32'h0);
        tick();
        chk_eq("t6_pcq_top", pcQ, 32'hFFFF_FFFC);
        chk_eq("t6_pc4_top", pcPlus4, 32'h0);
        tick();
        chk_eq("t6_pcq_wrap", pcQ, 32'h0);
        chk_eq("t6_pc4_wrap", pcPlus4, 32'h4);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_outputs_zero("t6_rst_now");
        tick();
        chk_outputs_zero("t6_rst_next");
        @(negedge clock);
        pop_q.delete();
        req_q.delete();
        reset = 1'b0;
        #1;
        chk_eq("t6_restart_valid", imemReqValid, 1'b1);
        chk_eq("t6_restart_addr", imemReqAddr, 32'h0);
        wait_pops(2, "t6_pop_count");
        chk_eq("t6_pop0", pop_q[0], 32'h0);
        chk_eq("t6_pop1", pop_q[1], 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
